// File: rtl/accum_sched.sv
// accum_sched: round-robin scheduler sharing one accumulate-and-compare datapath
// between NREQ requesters. Each grant streams NBEAT operands, sums them, and
// latches alarm = (acc > THRESH).
// Optional build macro ACCUM_SAT_EN: when defined, acc saturates at 2^ACC_W-1;
// otherwise acc wraps modulo 2^ACC_W.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among req from the round-robin pointer
// GRANT | one cycle: clear acc and beat count, advance pointer
// ACCUM | accept operands from owner while dvalid; NBEAT beats -> CHECK
// CHECK | one cycle: alarm <= (acc > THRESH)
// DONE  | result held; wait for owner to drop req
module accum_sched #(
  parameter int NREQ   = 2,
  parameter int DW     = 2,
  parameter int NBEAT  = 3,
  parameter int ACC_W  = 4,
  parameter int THRESH = 5,
  localparam int OW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW    = $clog2(NBEAT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  input  logic [NREQ-1:0]      dvalid,
  output logic [NREQ-1:0]      dready,
  output logic [NREQ-1:0]      gnt,
  output logic [OW-1:0]        owner,
  output logic [ACC_W-1:0]     acc,
  output logic                 busy,
  output logic                 done,
  output logic                 alarm
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ACCUM = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, ptr_q, pick, ptr_nxt;
  logic [ACC_W-1:0]  acc_q, acc_add;
  logic [CW-1:0]     cnt_q;
  logic              alarm_q;
  logic              found;
  logic              own_req, beat, last_beat;
  logic [NREQ-1:0]   owner_hot;
  logic [DW-1:0]     slot;

  assign own_req   = req[owner_q];
  assign beat      = dvalid[owner_q];
  assign last_beat = (cnt_q == CW'(NBEAT - 1));
  assign owner_hot = NREQ'(1) << owner_q;
  assign slot      = din[owner_q*DW +: DW];
  assign ptr_nxt   = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + OW'(1);

  // Round-robin pick: first set req bit at or after the pointer, wrapping.
  always_comb begin
    logic [OW-1:0] cand;
    pick  = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = OW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Accumulate one operand; overflow policy chosen at build time.
`ifdef ACCUM_SAT_EN
  always_comb begin
    logic [ACC_W:0] sum;
    sum     = {1'b0, acc_q} + (ACC_W+1)'(slot);
    acc_add = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_add = acc_q + ACC_W'(slot);
  end
`endif

  // Next-state logic; losing the owner's req in GRANT/ACCUM aborts to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = GRANT;
      GRANT:   state_d = own_req ? ACCUM : IDLE;
      ACCUM: begin
        if (!own_req)              state_d = IDLE;
        else if (beat && last_beat) state_d = CHECK;
      end
      CHECK:   state_d = DONE;
      DONE:    if (!own_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Owner, pointer, accumulator, beat counter and alarm registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= '0;
      ptr_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (found) owner_q <= pick;
        GRANT: begin
          acc_q <= '0;
          cnt_q <= '0;
          ptr_q <= ptr_nxt;
        end
        ACCUM: if (beat) begin
          acc_q <= acc_add;
          cnt_q <= cnt_q + CW'(1);
        end
        CHECK: alarm_q <= (int'(acc_q) > THRESH);
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign gnt    = busy ? owner_hot : '0;
  assign dready = (state_q == ACCUM) ? owner_hot : '0;
  assign owner  = owner_q;
  assign acc    = acc_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_accum_sched.sv
// Bench for accum_sched: directed table, reset/abort/arbitration sequences,
// randomized transactions against a round-robin + arithmetic model, and an
// NBEAT=6 instance exercising accumulator overflow (ACCUM_SAT_EN aware).
module tb_accum_sched;
  localparam int NREQ = 2, DW = 2, NBEAT = 3, ACC_W = 4, THRESH = 5;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] req, dvalid, dready, gnt;
  logic [3:0] din, acc;
  logic [0:0] owner;
  logic busy, done, alarm;

  logic [1:0] req6, dvalid6, dready6, gnt6;
  logic [3:0] din6, acc6;
  logic [0:0] owner6;
  logic busy6, done6, alarm6;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  logic m_alarm = 1'b0;

  typedef struct {
    int who;
    int op0, op1, op2;
    int exp_acc;
    int exp_alarm;
  } vec_t;
  vec_t tbl[6];

  accum_sched #(.NREQ(NREQ), .DW(DW), .NBEAT(NBEAT), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .dvalid(dvalid),
    .dready(dready), .gnt(gnt), .owner(owner), .acc(acc),
    .busy(busy), .done(done), .alarm(alarm));

  accum_sched #(.NREQ(NREQ), .DW(DW), .NBEAT(6), .ACC_W(ACC_W), .THRESH(THRESH)) dut6 (
    .clk(clk), .reset(reset), .req(req6), .din(din6), .dvalid(dvalid6),
    .dready(dready6), .gnt(gnt6), .owner(owner6), .acc(acc6),
    .busy(busy6), .done(done6), .alarm(alarm6));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int who, int a, int b, int c, int ea, int eal);
    vec_t v;
    v.who = who; v.op0 = a; v.op1 = b; v.op2 = c;
    v.exp_acc = ea; v.exp_alarm = eal;
    return v;
  endfunction

  // Model arbitration: first requesting index at or after the model pointer.
  function automatic int pick(input int mask);
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (m_ptr + i) % NREQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic wait_gnt(input int exp_who);
    int g = 0;
    while (gnt == 0 && g < 20) begin tick(); g++; end
    chk("gnt", gnt, 1 << exp_who);
    chk("owner", owner, exp_who);
    m_ptr = (exp_who + 1) % NREQ;
  endtask

  task automatic beat(input int who, input int val, input int exp_acc);
    int g = 0;
    din[who*DW +: DW] = DW'(val);
    dvalid[who] = 1'b1;
    while (!dready[who] && g < 20) begin tick(); g++; end
    chk("dready_wait", dready[who], 1);
    tick();
    dvalid[who] = 1'b0;
    chk("acc_beat", acc, exp_acc);
  endtask

  task automatic finish(input int who, input int exp_acc, input logic exp_alarm);
    chk("check_done", done, 0);
    chk("check_dready", dready, 0);
    chk("check_alarm_hold", alarm, m_alarm);
    tick();
    chk("done", done, 1);
    chk("alarm", alarm, exp_alarm);
    chk("acc_final", acc, exp_acc);
    m_alarm = exp_alarm;
    tick(); tick();
    chk("done_hold", done, 1);
    chk("gnt_hold", gnt, 1 << who);
    req[who] = 1'b0;
    tick();
    chk("busy_idle", busy, 0);
    chk("done_idle", done, 0);
  endtask

  initial begin
    int s, ops[3], mask, who, n, g;
    reset = 1'b0; req = '0; dvalid = '0; din = '0;
    req6 = '0; dvalid6 = '0; din6 = '0;
    tick(); tick();
    chk("rst_gnt", gnt, 0); chk("rst_dready", dready, 0); chk("rst_owner", owner, 0);
    chk("rst_acc", acc, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_alarm", alarm, 0);
    reset = 1'b1;
    tick();

    tbl[0] = mk(0, 2, 3, 1, 6, 1);
    tbl[1] = mk(0, 1, 1, 1, 3, 0);
    tbl[2] = mk(1, 3, 3, 0, 6, 1);
    tbl[3] = mk(1, 1, 2, 2, 5, 0);
    tbl[4] = mk(0, 0, 0, 0, 0, 0);
    tbl[5] = mk(1, 3, 3, 3, 9, 1);
    for (int i = 0; i < 6; i++) begin
      req[tbl[i].who] = 1'b1;
      wait_gnt(tbl[i].who);
      ops[0] = tbl[i].op0; ops[1] = tbl[i].op1; ops[2] = tbl[i].op2;
      s = 0;
      for (int k = 0; k < NBEAT; k++) begin
        s = s + ops[k];
        beat(tbl[i].who, ops[k], s);
      end
      finish(tbl[i].who, tbl[i].exp_acc, tbl[i].exp_alarm[0]);
    end

    // Asynchronous reset in the middle of ACCUM.
    req = 2'b10;
    wait_gnt(1);
    beat(1, 1, 1);
    beat(1, 2, 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0); chk("arst_dready", dready, 0); chk("arst_owner", owner, 0);
    chk("arst_acc", acc, 0); chk("arst_busy", busy, 0); chk("arst_alarm", alarm, 0);
    req = '0; dvalid = '0; m_ptr = 0; m_alarm = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("arst_idle", busy, 0);

    // Simultaneous requests resolved by the pointer.
    req = 2'b11;
    wait_gnt(pick(3));
    beat(0, 1, 1); beat(0, 1, 2); beat(0, 1, 3);
    finish(0, 3, 1'b0);
    wait_gnt(1);
    beat(1, 2, 2); beat(1, 2, 4); beat(1, 2, 6);
    finish(1, 6, 1'b1);
    req = 2'b11;
    wait_gnt(pick(3));
    beat(0, 3, 3); beat(0, 3, 6); beat(0, 0, 6);
    finish(0, 6, 1'b1);
    req = '0;

    // Stall, then abort after two beats.
    req = 2'b10;
    wait_gnt(pick(2));
    beat(1, 2, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_acc", acc, 2);
      chk("stall_done", done, 0);
    end
    beat(1, 1, 3);
    req[1] = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_acc", acc, 3);
    chk("abort_alarm", alarm, m_alarm);
    chk("abort_done", done, 0);
    req = 2'b11;
    wait_gnt(pick(3));
    beat(0, 1, 1); beat(0, 0, 1); beat(0, 0, 1);
    finish(0, 1, 1'b0);
    req = '0;

    // Randomized transactions.
    for (int it = 0; it < 30; it++) begin
      mask = $urandom_range(1, 3);
      who = pick(mask);
      din = 4'($urandom);
      req = 2'(mask);
      wait_gnt(who);
      s = 0;
      for (int k = 0; k < NBEAT; k++) begin
        int v;
        repeat ($urandom_range(0, 2)) tick();
        v = $urandom_range(0, 3);
        s = (s + v) % 16;
        beat(who, v, s);
      end
      finish(who, s, s > THRESH);
      req = '0;
    end

    // NBEAT=6 instance: six beats of 3 overflow a 4-bit accumulator.
    req6 = 2'b01;
    g = 0;
    while (gnt6 == 0 && g < 20) begin tick(); g++; end
    chk("ovf_gnt", gnt6, 1);
    chk("ovf_owner", owner6, 0);
    din6 = 4'b0011;
    dvalid6[0] = 1'b1;
    n = 0; s = 0; g = 0;
    while (n < 6 && g < 40) begin
      if (dready6[0]) begin
        n++;
`ifdef ACCUM_SAT_EN
        s = (s + 3 > 15) ? 15 : s + 3;
`else
        s = (s + 3) % 16;
`endif
      end
      tick();
      g++;
    end
    dvalid6 = '0;
    chk("ovf_beats", n, 6);
    tick();
    chk("ovf_done", done6, 1);
    chk("ovf_acc", acc6, s);
    chk("ovf_alarm", alarm6, s > THRESH);
    req6 = '0;
    tick();
    chk("ovf_busy", busy6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/accum_sched.md
Name: accum_sched

Overview:
- Round-robin scheduler that shares one accumulate-and-compare datapath between NREQ requesters.
- Each granted requester streams NBEAT operands through a valid/ready handshake.
- The block sums the operands in an internal accumulator, compares the total against THRESH, and reports the alarm flag and owner id back to that requester.
- Sits between the requesters and the alarm logic; it replaces single-user go/ok sequencing with arbitrated multi-user access.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 2, operand width per beat.
- NBEAT, 3, operands accumulated per grant (1..15).
- ACC_W, 4, accumulator width.
- THRESH, 5, alarm when accumulator > THRESH (unsigned).

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, reset; asynchronous, active-low.
- req, input, NREQ, request per requester; held high through DONE.
- din, input, NREQ*DW, operand of requester i at [i*DW +: DW].
- dvalid, input, NREQ, operand-valid per requester.
- dready, output, NREQ, operand accepted this cycle (one-hot or zero).
- gnt, output, NREQ, one-hot grant, zero when idle.
- owner, output, clog2(NREQ) (min 1), index of current or last owner.
- acc, output, ACC_W, accumulator value.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, high while in DONE.
- alarm, output, 1, registered result of the last completed check.

Behaviour:
- One clock; reset is asynchronous and active-low. Assertion forces IDLE immediately.
- Reset values: gnt=0, dready=0, owner=0, acc=0, busy=0, done=0, alarm=0, round-robin pointer=0, beat counter=0.
- States:
  - IDLE: if any req bit is set, pick the first set bit at or after the pointer (wrapping), latch owner, go to GRANT. Otherwise stay.
  - GRANT: one cycle. gnt[owner]=1, acc cleared to 0, beat counter=0, pointer <= (owner+1) mod NREQ. Go to ACCUM.
  - ACCUM: gnt[owner]=1, dready[owner]=1.
    - A beat is accepted when dvalid[owner] is high.
    - On each accepted beat: acc <= acc + zero-extended din slot, and the counter increments.
    - dvalid low stalls with no change.
    - On the NBEAT-th accepted beat, go to CHECK.
  - CHECK: one cycle, gnt held, dready=0. alarm <= (acc > THRESH). Go to DONE.
  - DONE: gnt held, done=1. Stay while req[owner]=1. When req[owner]=0, go to IDLE; arbitration resumes on the following cycle.
- Abort: req[owner] low in GRANT or ACCUM → IDLE next cycle.
  - No CHECK is performed and alarm is unchanged.
  - acc keeps its partial value until the next GRANT.
  - The pointer stays advanced.
- Requests from non-owners are ignored until IDLE. Requesters may raise or drop req freely while not granted.
- Simultaneous requests are resolved by the pointer. After owner i, requester i+1 has top priority, giving starvation-free round robin.
- Latency: req seen in IDLE → gnt one cycle later (GRANT). Minimum total from req to done is NBEAT+3 cycles with dvalid held high.
- owner, acc and alarm hold their values in IDLE. alarm changes only in CHECK.
- Overflow handling for acc is set by the optional feature.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined: acc saturates at 2^ACC_W-1 and stays there for the rest of the grant.
- Undefined: acc wraps modulo 2^ACC_W; the carry is discarded.
- The comparison always uses the stored acc value.

Test Plan:
- Reset asserted low mid-ACCUM (acc=3) → all outputs 0 asynchronously; state IDLE after release; a new req0 is granted from pointer 0.
- NREQ=2, req0 only, beats 2,3,1 with dvalid high → gnt=01; acc 0→2→5→6; alarm=1 one cycle after the last beat; done=1 until req0 drops, then busy=0.
- req0, beats 1,1,1 → acc=3, alarm=0, owner=0.
- req0 and req1 both raised at the same cycle after reset → req0 served first; after req0 drops, req1 granted (gnt=10); then req0 re-raised is granted before a simultaneous req1.
- req1 granted; dvalid low for 4 cycles between beats; then req1 dropped after 2 beats → no acc change during the stall; IDLE on abort; done never asserted; alarm unchanged.
- NBEAT=6, six beats of 3 → acc=15 with ACCUM_SAT_EN defined, acc=2 without (18 mod 16); alarm=1 with the macro, 0 without.
